// File: rtl/bp_update_sched.sv
// Branch direction table update scheduler: init sweep, queued read-modify-write
// counter updates, cfg-write arbitration and misprediction flush/redirect.
module bp_update_sched #(
  parameter int unsigned IDX_W      = 7,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [1:0]  INIT_STATE = 2'b00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [31:0]      res_pc,
  input  logic [31:0]      res_target,
  input  logic             res_taken,
  input  logic             res_pred_dir,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [1:0]       cfg_state,
  output logic             tbl_rd_en,
  output logic [IDX_W-1:0] tbl_rd_idx,
  input  logic [1:0]       tbl_rd_data,
  output logic             tbl_wr_en,
  output logic [IDX_W-1:0] tbl_wr_idx,
  output logic [1:0]       tbl_wr_data,
  output logic             flush,
  output logic [31:0]      redirect_pc,
  output logic             init_busy,
  output logic [31:0]      mispredict_cnt
);

  localparam int unsigned     PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StInit, StIdle, StRdWait} state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   sweep_q;
  logic [IDX_W:0]     fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     fifo_cnt_q;
  logic               last_grant_q;  // 1: cfg won most recently, so FIFO goes next
  logic [IDX_W-1:0]   upd_idx_q;
  logic               upd_taken_q;
  logic               flush_q;
  logic [31:0]        redirect_q;
  logic [31:0]        misp_cnt_q;

  logic               accept, mispredict, in_idle, fifo_empty;
  logic               grant_fifo, grant_cfg;
  logic [IDX_W:0]     head;
  logic [1:0]         upd_data;

  assign init_busy      = rst || (state_q == StInit);
  assign fifo_empty     = (fifo_cnt_q == '0);
  assign res_ready      = !init_busy && (fifo_cnt_q != FULL_CNT);
  assign accept         = res_valid && res_ready;
  assign mispredict     = accept && (res_taken != res_pred_dir);
  assign in_idle        = !rst && (state_q == StIdle);
  assign grant_fifo     = in_idle && !fifo_empty && (!cfg_valid || last_grant_q);
  assign grant_cfg      = in_idle && cfg_valid && !grant_fifo;
  assign head           = fifo_mem[rd_ptr_q];
  assign flush          = flush_q;
  assign redirect_pc    = redirect_q;
  assign mispredict_cnt = misp_cnt_q;

  always_comb begin
    if (upd_taken_q) begin
      upd_data = (tbl_rd_data == 2'b11) ? 2'b11 : tbl_rd_data + 2'b01;
    end else begin
      upd_data = (tbl_rd_data == 2'b00) ? 2'b00 : tbl_rd_data - 2'b01;
    end
  end

  always_comb begin
    cfg_ready   = 1'b0;
    tbl_rd_en   = 1'b0;
    tbl_rd_idx  = '0;
    tbl_wr_en   = 1'b0;
    tbl_wr_idx  = '0;
    tbl_wr_data = '0;
    // Reset suppresses every strobe, even when caught mid-update
    if (!rst) begin
      unique case (state_q)
        StInit: begin
          tbl_wr_en   = 1'b1;
          tbl_wr_idx  = sweep_q;
          tbl_wr_data = INIT_STATE;
        end
        StIdle: begin
          if (grant_fifo) begin
            tbl_rd_en  = 1'b1;
            tbl_rd_idx = head[IDX_W:1];
          end else if (grant_cfg) begin
            cfg_ready   = 1'b1;
            tbl_wr_en   = 1'b1;
            tbl_wr_idx  = cfg_idx;
            tbl_wr_data = cfg_state;
          end
        end
        StRdWait: begin
          tbl_wr_en   = 1'b1;
          tbl_wr_idx  = upd_idx_q;
          tbl_wr_data = upd_data;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_mem[wr_ptr_q] <= {res_pc[IDX_W+1:2], res_taken};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StInit;
      sweep_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      last_grant_q <= 1'b1;
      upd_idx_q    <= '0;
      upd_taken_q  <= 1'b0;
      flush_q      <= 1'b0;
      redirect_q   <= '0;
      misp_cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StInit: begin
          sweep_q <= sweep_q + IDX_W'(1);
          if (sweep_q == '1) state_q <= StIdle;
        end
        StIdle: begin
          if (grant_fifo) begin
            upd_idx_q    <= head[IDX_W:1];
            upd_taken_q  <= head[0];
            last_grant_q <= 1'b0;
            state_q      <= StRdWait;
          end else if (grant_cfg) begin
            last_grant_q <= 1'b1;
          end
        end
        StRdWait: state_q <= StIdle;
        default:  state_q <= StInit;
      endcase

      if (accept)     wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (grant_fifo) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({accept, grant_fifo})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + (PTR_W+1)'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - (PTR_W+1)'(1);
        default: ;
      endcase

      flush_q <= mispredict;
      if (mispredict) begin
        redirect_q <= res_taken ? res_target : res_pc + 32'd4;
        if (misp_cnt_q != '1) misp_cnt_q <= misp_cnt_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_bp_update_sched.sv
// Bench for bp_update_sched: transaction-level model (queue + table contents)
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_bp_update_sched;

  localparam int IDX_W = 7;
  localparam int DEPTH = 128;
  localparam int FDEP  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             res_valid, res_ready, res_taken, res_pred_dir;
  logic [31:0]      res_pc, res_target;
  logic             cfg_valid, cfg_ready;
  logic [IDX_W-1:0] cfg_idx;
  logic [1:0]       cfg_state;
  logic             tbl_rd_en, tbl_wr_en;
  logic [IDX_W-1:0] tbl_rd_idx, tbl_wr_idx;
  logic [1:0]       tbl_rd_data = 2'b00;
  logic [1:0]       tbl_wr_data;
  logic             flush, init_busy;
  logic [31:0]      redirect_pc, mispredict_cnt;

  always #5 clk = ~clk;

  bp_update_sched #(.IDX_W(IDX_W), .FIFO_DEPTH(FDEP), .INIT_STATE(2'b00)) dut (
    .clk(clk), .rst(rst),
    .res_valid(res_valid), .res_ready(res_ready), .res_pc(res_pc),
    .res_target(res_target), .res_taken(res_taken), .res_pred_dir(res_pred_dir),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx), .cfg_state(cfg_state),
    .tbl_rd_en(tbl_rd_en), .tbl_rd_idx(tbl_rd_idx), .tbl_rd_data(tbl_rd_data),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_idx(tbl_wr_idx), .tbl_wr_data(tbl_wr_data),
    .flush(flush), .redirect_pc(redirect_pc), .init_busy(init_busy),
    .mispredict_cnt(mispredict_cnt)
  );

  // Table RAM with 1-cycle read latency
  logic [1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (tbl_wr_en) mem[tbl_wr_idx] <= tbl_wr_data;
    if (tbl_rd_en) tbl_rd_data <= mem[tbl_rd_idx];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] sat_upd(input logic [1:0] v, input bit t);
    if (t) return (v == 2'd3) ? 2'd3 : v + 2'd1;
    return (v == 2'd0) ? 2'd0 : v - 2'd1;
  endfunction

  // Model: pending resolutions, one update in flight, expected table contents
  typedef struct {int idx; bit taken;} ent_t;
  ent_t        q[$];
  int          init_left, sweep, infl_idx;
  bit          infl, infl_taken, last_cfg, m_valid = 1'b0, m_flush;
  logic [1:0]  mtbl [DEPTH];
  logic [31:0] m_redir, m_cnt;
  bit          e_rr, e_cr, e_rd, e_wr, e_gfifo, e_gcfg;
  int          e_rd_idx, e_wr_idx;
  logic [1:0]  e_wr_data;
  logic [1:0]  w10[$];

  always @(negedge clk) begin
    if (m_valid) begin
      {e_rr, e_cr, e_rd, e_wr, e_gfifo, e_gcfg} = '0;
      e_rd_idx = 0; e_wr_idx = 0; e_wr_data = 2'b00;
      if (!rst) begin
        if (init_left > 0) begin
          e_wr = 1; e_wr_idx = sweep; e_wr_data = 2'b00;
        end else if (infl) begin
          e_wr = 1; e_wr_idx = infl_idx; e_wr_data = sat_upd(mtbl[infl_idx], infl_taken);
        end else if (q.size() > 0 && (!cfg_valid || last_cfg)) begin
          e_gfifo = 1; e_rd = 1; e_rd_idx = q[0].idx;
        end else if (cfg_valid) begin
          e_gcfg = 1; e_cr = 1; e_wr = 1; e_wr_idx = int'(cfg_idx); e_wr_data = cfg_state;
        end
        e_rr = (init_left == 0) && (q.size() < FDEP);
      end
      chk("res_ready", res_ready, e_rr);
      chk("cfg_ready", cfg_ready, e_cr);
      chk("tbl_rd_en", tbl_rd_en, e_rd);
      chk("tbl_wr_en", tbl_wr_en, e_wr);
      chk("init_busy", init_busy, (rst || init_left > 0));
      chk("flush", flush, m_flush);
      chk("redirect_pc", redirect_pc, m_redir);
      chk("mispredict_cnt", mispredict_cnt, m_cnt);
      if (e_rd) chk("tbl_rd_idx", tbl_rd_idx, e_rd_idx);
      if (e_wr) begin
        chk("tbl_wr_idx", tbl_wr_idx, e_wr_idx);
        chk("tbl_wr_data", tbl_wr_data, e_wr_data);
      end
      if (tbl_wr_en && tbl_wr_idx == 7'h10 && !init_busy) w10.push_back(tbl_wr_data);
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      init_left = DEPTH; sweep = 0; q.delete(); infl = 0; last_cfg = 1;
      m_flush = 0; m_redir = '0; m_cnt = '0; m_valid = 1;
    end else if (m_valid) begin
      if (init_left > 0) begin
        mtbl[sweep] = 2'b00; sweep++; init_left--;
      end else if (infl) begin
        mtbl[infl_idx] = sat_upd(mtbl[infl_idx], infl_taken); infl = 0;
      end else if (e_gfifo) begin
        infl = 1; infl_idx = q[0].idx; infl_taken = q[0].taken; void'(q.pop_front());
        last_cfg = 0;
      end else if (e_gcfg) begin
        mtbl[int'(cfg_idx)] = cfg_state; last_cfg = 1;
      end
      m_flush = 0;
      if (res_valid && e_rr) begin
        q.push_back('{idx: int'(res_pc[IDX_W+1:2]), taken: res_taken});
        if (res_taken != res_pred_dir) begin
          m_flush = 1;
          m_redir = res_taken ? res_target : res_pc + 32'd4;
          if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_res(input logic [31:0] pc, input logic [31:0] tgt,
                           input logic tk, input logic pd);
    res_valid = 1'b1; res_pc = pc; res_target = tgt; res_taken = tk; res_pred_dir = pd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, acc, drop, lat, ncfg, nrd;
    bit found;
    logic [1:0] exp10 [4];
    exp10 = '{2'b01, 2'b10, 2'b11, 2'b11};
    res_valid = 0; res_pc = '0; res_target = '0; res_taken = 0; res_pred_dir = 0;
    cfg_valid = 0; cfg_idx = '0; cfg_state = '0;
    rst = 1;
    cyc();
    chk("rst_init_busy", init_busy, 1);
    chk("rst_cnt", mispredict_cnt, 0);
    chk("rst_flush", flush, 0);
    chk("rst_redirect", redirect_pc, 0);
    rst = 0;

    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!init_busy) break;
      n++;
    end
    chk("init_len", n, 128);
    chk("ready_after_init", res_ready, 1);
    cyc();

    // Three mispredicted taken branches at idx 0x10, then a correct one
    drive_res(32'h40, 32'h1000, 1, 0); cyc();
    chk("m1_flush", flush, 1); chk("m1_redir", redirect_pc, 32'h1000);
    chk("m1_cnt", mispredict_cnt, 1);
    drive_res(32'h40, 32'h2000, 1, 0); cyc();
    chk("m2_flush", flush, 1); chk("m2_redir", redirect_pc, 32'h2000);
    drive_res(32'h40, 32'h3000, 1, 0); cyc();
    chk("m3_redir", redirect_pc, 32'h3000); chk("m3_cnt", mispredict_cnt, 3);
    drive_res(32'h40, 32'h4000, 1, 1); cyc();
    chk("m4_flush", flush, 0); chk("m4_redir_hold", redirect_pc, 32'h3000);
    chk("m4_cnt", mispredict_cnt, 3);
    res_valid = 0;
    repeat (10) cyc();
    chk("w10_count", w10.size(), 4);
    for (int i = 0; i < 4; i++) chk("w10_data", (i < w10.size()) ? w10[i] : 2'bxx, exp10[i]);

    // Not-taken mispredict at top of address space wraps the fall-through
    drive_res(32'hFFFF_FFFC, 32'h5000, 0, 1); cyc();
    chk("wrap_flush", flush, 1); chk("wrap_redir", redirect_pc, 32'h0);
    chk("wrap_cnt", mispredict_cnt, 4);
    res_valid = 0;
    repeat (4) cyc();

    // Sustained resolutions: FIFO fills, back-pressure, in-order drain
    acc = 0; drop = 0; n = 0;
    for (int k = 0; k < 12; k++) begin
      drive_res(32'h100 + 32'(n) * 4, 32'h0, n[0], n[0]);
      if (res_ready) begin acc++; n++; end
      else if (drop == 0) drop = k + 1;
      cyc();
    end
    chk("burst_accepts", acc, 9);
    chk("burst_first_full", drop, 8);
    res_valid = 0;
    repeat (8) cyc();
    chk("burst_drained_ready", res_ready, 1);

    // cfg competes with a continuously non-empty FIFO
    for (int k = 0; k < 4; k++) begin drive_res(32'hC0, 32'h0, 1, 1); cyc(); end
    cfg_valid = 1; cfg_idx = 7'h30; cfg_state = 2'b10;
    lat = 0; ncfg = 0; nrd = 0; found = 0;
    for (int k = 0; k < 9; k++) begin
      if (cfg_ready) begin ncfg++; found = 1; end
      else if (!found) lat++;
      if (tbl_rd_en) nrd++;
      cyc();
    end
    chk("cfg_latency_le3", (lat <= 3), 1);
    chk("cfg_grants", ncfg, 3);
    chk("fifo_grants", nrd, 3);
    cfg_valid = 0;

    // Reset caught in RD_WAIT with three entries still queued
    found = 0;
    for (int k = 0; k < 20; k++) begin
      if (tbl_rd_en && !res_ready) begin found = 1; break; end
      cyc();
    end
    chk("wait_full_pop", found, 1);
    res_valid = 0;
    cyc();
    chk("pre_rst_rdwait_wr", tbl_wr_en, 1);
    rst = 1;
    #1;
    chk("rst_no_wr", tbl_wr_en, 0);
    cyc();
    rst = 0;
    #1;
    chk("rst2_flush", flush, 0);
    chk("rst2_cnt", mispredict_cnt, 0);
    chk("rst2_busy", init_busy, 1);
    chk("rst2_sweep_idx", tbl_wr_idx, 0);
    found = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!init_busy) begin found = 1; break; end
    end
    chk("rst2_init_done", found, 1);
    cyc();
    repeat (5) cyc();
    chk("rst2_fifo_empty_no_rd", tbl_rd_en, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
